voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 185 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto NUM_VOICES voices
// with retrigger, free-voice and oldest-voice-steal policies, one voice scanned per cycle.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int MIDI_BITS  = 7,
  parameter int VEL_BITS   = 7,
  parameter int AGE_BITS   = 4
) (
  input  logic                            clk_i,
  input  logic                            n_rst_i,
  input  logic                            ev_valid_i,
  output logic                            ev_ready_o,
  input  logic                            ev_on_i,
  input  logic [MIDI_BITS-1:0]            ev_note_i,
  input  logic [VEL_BITS-1:0]             ev_vel_i,
  output logic [NUM_VOICES*MIDI_BITS-1:0] voice_note_o,
  output logic [NUM_VOICES*VEL_BITS-1:0]  voice_vel_o,
  output logic [NUM_VOICES-1:0]           voice_gate_o,
  output logic [NUM_VOICES-1:0]           voice_trig_o,
  output logic                            steal_o
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ev_on_q, ev_on_d;
  logic [MIDI_BITS-1:0] ev_note_q, ev_note_d;
  logic [VEL_BITS-1:0]  ev_vel_q, ev_vel_d;

  logic                 hit_q, hit_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
  logic                 free_q, free_d;
  logic [IDX_W-1:0]     free_idx_q, free_idx_d;
  logic [IDX_W-1:0]     old_idx_q, old_idx_d;
  logic [AGE_BITS-1:0]  old_age_q, old_age_d;

  logic [MIDI_BITS-1:0] note_q [NUM_VOICES];
  logic [MIDI_BITS-1:0] note_d [NUM_VOICES];
  logic [VEL_BITS-1:0]  vel_q  [NUM_VOICES];
  logic [VEL_BITS-1:0]  vel_d  [NUM_VOICES];
  logic [AGE_BITS-1:0]  age_q  [NUM_VOICES];
  logic [AGE_BITS-1:0]  age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  steal_q, steal_d;

  logic                 is_on;
  logic [IDX_W-1:0]     sel;

  // A zero-velocity note-on is a note-off in MIDI running-status practice.
  assign is_on = ev_on_q && (ev_vel_q != '0);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    ev_vel_d   = ev_vel_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    free_d     = free_q;
    free_idx_d = free_idx_q;
    old_idx_d  = old_idx_q;
    old_age_d  = old_age_q;
    note_d     = note_q;
    vel_d      = vel_q;
    age_d      = age_q;
    gate_d     = gate_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    sel        = old_idx_q;

    case (state_q)
      S_IDLE: begin
        if (ev_valid_i) begin
          ev_on_d   = ev_on_i;
          ev_note_d = ev_note_i;
          ev_vel_d  = ev_vel_i;
          idx_d     = '0;
          hit_d     = 1'b0;
          free_d    = 1'b0;
          old_idx_d = '0;
          old_age_d = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (gate_q[idx_q] && (note_q[idx_q] == ev_note_q) && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
        end
        if (!gate_q[idx_q] && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict greater-than keeps the lowest index on age ties.
        if ((idx_q == '0) || (age_q[idx_q] > old_age_q)) begin
          old_idx_d = idx_q;
          old_age_d = age_q[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = S_COMMIT;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (is_on) begin
          if (hit_q)       sel = hit_idx_q;
          else if (free_q) sel = free_idx_q;
          else             sel = old_idx_q;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && (age_q[v] != '1)) age_d[v] = age_q[v] + 1'b1;
          end
          note_d[sel] = ev_note_q;
          vel_d[sel]  = ev_vel_q;
          gate_d[sel] = 1'b1;
          age_d[sel]  = '0;
          trig_d[sel] = 1'b1;
          steal_d     = !hit_q && !free_q;
        end else begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && (note_q[v] == ev_note_q)) gate_d[v] = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_vel_q   <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      old_idx_q  <= '0;
      old_age_q  <= '0;
      gate_q     <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ev_on_q    <= ev_on_d;
      ev_note_q  <= ev_note_d;
      ev_vel_q   <= ev_vel_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      free_q     <= free_d;
      free_idx_q <= free_idx_d;
      old_idx_q  <= old_idx_d;
      old_age_q  <= old_age_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      age_q      <= age_d;
    end
  end

  assign ev_ready_o   = (state_q == S_IDLE);
  assign voice_gate_o = gate_q;
  assign voice_trig_o = trig_q;
  assign steal_o      = steal_q;

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
    assign voice_note_o[gv*MIDI_BITS +: MIDI_BITS] = note_q[gv];
    assign voice_vel_o[gv*VEL_BITS +: VEL_BITS]    = vel_q[gv];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed events push hand-computed voice
// snapshots; a monitor pops one whenever ev_ready_o returns high after an event.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        ev_valid, ev_on;
  logic [6:0]  ev_note, ev_vel;
  logic        ev_ready;
  logic [27:0] v_note, v_vel;
  logic [3:0]  v_gate, v_trig;
  logic        steal;

  typedef struct packed {
    logic [3:0]  gate;
    logic [27:0] notes;
    logic [27:0] vels;
    logic [3:0]  trig;
    logic        steal;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   lowcnt = 0;
  bit   prev_rdy = 1'b1;

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .ev_valid_i(ev_valid), .ev_ready_o(ev_ready),
    .ev_on_i(ev_on), .ev_note_i(ev_note), .ev_vel_i(ev_vel),
    .voice_note_o(v_note), .voice_vel_o(v_vel), .voice_gate_o(v_gate),
    .voice_trig_o(v_trig), .steal_o(steal)
  );

  // Voice 0 sits in the least significant field.
  function automatic logic [27:0] pk(input logic [6:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic [27:0] n, input logic [27:0] ve,
                              input logic [3:0] t, input logic s);
    exp_t e;
    e.gate = g; e.notes = n; e.vels = ve; e.trig = t; e.steal = s;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_rdy = 1'b1;
        lowcnt   = 0;
      end else begin
        if (!ev_ready) lowcnt++;
        if (ev_ready && !prev_rdy) begin
          if (q.size() == 0) begin
            chk("unexpected_commit", 64'(v_gate), 64'hDEAD);
          end else begin
            e = q.pop_front();
            chk("gate",  64'(v_gate), 64'(e.gate));
            chk("notes", 64'(v_note), 64'(e.notes));
            chk("vels",  64'(v_vel),  64'(e.vels));
            chk("trig",  64'(v_trig), 64'(e.trig));
            chk("steal", 64'(steal),  64'(e.steal));
            chk("busy_cycles", 64'(lowcnt), 64'd5);
          end
          lowcnt = 0;
        end else begin
          chk("pulse_outside_commit", 64'({v_trig, steal}), 64'd0);
        end
        prev_rdy = ev_ready;
      end
    end
  endtask

  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel,
                      input exp_t e, input bit push);
    int w = 0;
    @(negedge clk);
    while (!ev_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ev_ready) begin
      chk("ready_timeout", 64'(ev_ready), 64'd1);
      return;
    end
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_vel = vel;
    if (push) q.push_back(e);
    @(posedge clk);
    #1 ev_valid = 1'b0;
    if (push) begin
      // Noise on the inputs while busy must be ignored.
      @(posedge clk);
      #1 ev_valid = 1'b1;
      ev_on = 1'($urandom); ev_note = 7'($urandom); ev_vel = 7'($urandom);
      repeat (2) @(posedge clk);
      #1 ev_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic stimulus();
    exp_t dummy;
    dummy = '0;
    n_rst = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    chk("rst_ready", 64'(ev_ready), 64'd1);
    chk("rst_gate",  64'(v_gate), 64'd0);
    chk("rst_notes", 64'(v_note), 64'd0);
    chk("rst_vels",  64'(v_vel),  64'd0);
    chk("rst_pulse", 64'({v_trig, steal}), 64'd0);

    // Fill all four voices, then steal the oldest twice.
    send(1, 60, 100, mk(4'b0001, pk(60,0,0,0),    pk(100,0,0,0),    4'b0001, 0), 1);
    send(1, 62,  90, mk(4'b0011, pk(60,62,0,0),   pk(100,90,0,0),   4'b0010, 0), 1);
    send(1, 64,  80, mk(4'b0111, pk(60,62,64,0),  pk(100,90,80,0),  4'b0100, 0), 1);
    send(1, 67,  70, mk(4'b1111, pk(60,62,64,67), pk(100,90,80,70), 4'b1000, 0), 1);
    send(1, 69,  50, mk(4'b1111, pk(69,62,64,67), pk(50,90,80,70),  4'b0001, 1), 1);
    send(1, 71,  40, mk(4'b1111, pk(69,71,64,67), pk(50,40,80,70),  4'b0010, 1), 1);
    drain();

    // Note-off frees voice0, which is then reused; unmatched off is a no-op.
    do_reset();
    send(1, 60, 100, mk(4'b0001, pk(60,0,0,0),  pk(100,0,0,0),  4'b0001, 0), 1);
    send(1, 62,  90, mk(4'b0011, pk(60,62,0,0), pk(100,90,0,0), 4'b0010, 0), 1);
    send(0, 60,  33, mk(4'b0010, pk(60,62,0,0), pk(100,90,0,0), 4'b0000, 0), 1);
    send(1, 72, 110, mk(4'b0011, pk(72,62,0,0), pk(110,90,0,0), 4'b0001, 0), 1);
    send(0, 99,   0, mk(4'b0011, pk(72,62,0,0), pk(110,90,0,0), 4'b0000, 0), 1);
    drain();

    // Retrigger same note, then zero-velocity note-on acts as note-off.
    do_reset();
    send(1, 60, 100, mk(4'b0001, pk(60,0,0,0),  pk(100,0,0,0), 4'b0001, 0), 1);
    send(1, 60,  20, mk(4'b0001, pk(60,0,0,0),  pk(20,0,0,0),  4'b0001, 0), 1);
    send(1, 65,  55, mk(4'b0011, pk(60,65,0,0), pk(20,55,0,0), 4'b0010, 0), 1);
    send(1, 65,   0, mk(4'b0001, pk(60,65,0,0), pk(20,55,0,0), 4'b0000, 0), 1);
    drain();

    // Reset in the middle of a scan abandons the event.
    send(1, 60, 100, dummy, 0);
    @(posedge clk);
    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    chk("abort_ready", 64'(ev_ready), 64'd1);
    chk("abort_gate",  64'(v_gate), 64'd0);
    chk("abort_notes", 64'(v_note), 64'd0);
    chk("abort_trig",  64'(v_trig), 64'd0);
    repeat (8) @(negedge clk);
    send(1, 62, 10, mk(4'b0001, pk(62,0,0,0), pk(10,0,0,0), 4'b0001, 0), 1);
    drain();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
